// File: rtl/prga_decrypt.sv
// -----------------------------------------------------------------------------
// prga_decrypt
//
// RC4 keystream generator and decryptor. Once key scheduling has filled the
// S-box RAM, this block takes over the single-port S bus. For each of
// MSG_LEN bytes it steps i and j, swaps S[i] and S[j] in place, reads
// S[S[i]+S[j]] as the keystream byte, and XORs it with the encrypted ROM byte.
// The result goes to the decrypted-message RAM.
//
// All three memories register address/data on a rising edge and present q in
// the following cycle. Addresses and strobes are driven combinationally from
// the state and the working registers.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   start           level request, sampled only in IDLE
//   busy            high while a byte loop is running (owns the S bus)
//   done            high in DONE, held until start is released
//   s_addr/s_wdata/s_wren/s_rdata   S-box RAM port
//   k_addr/k_rdata                  encrypted message ROM port
//   d_addr/d_wdata/d_wren           decrypted message RAM write port
// -----------------------------------------------------------------------------
module prga_decrypt #(
    parameter int MSG_LEN = 32,
    parameter int MSG_AW  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [7:0]        s_addr,
    output logic [7:0]        s_wdata,
    output logic              s_wren,
    input  logic [7:0]        s_rdata,
    output logic [MSG_AW-1:0] k_addr,
    input  logic [7:0]        k_rdata,
    output logic [MSG_AW-1:0] d_addr,
    output logic [7:0]        d_wdata,
    output logic              d_wren
);

    // One extra bit on k so a 2^MSG_AW-byte message can still be counted.
    localparam int K_W = MSG_AW + 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(MSG_LEN - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_I,
        ST_GET_I,
        ST_RD_J,
        ST_GET_J,
        ST_WR_I,
        ST_WR_J,
        ST_RD_F,
        ST_GET_F,
        ST_WR_D,
        ST_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [7:0]     i_q, i_d;
    logic [7:0]     j_q, j_d;
    logic [7:0]     si_q, si_d;
    logic [7:0]     sj_q, sj_d;
    logic [7:0]     f_q, f_d;
    logic [7:0]     enc_q, enc_d;
    logic [K_W-1:0] k_q, k_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            f_q     <= '0;
            enc_q   <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            f_q     <= f_d;
            enc_q   <= enc_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        si_d    = si_q;
        sj_d    = sj_q;
        f_d     = f_q;
        enc_d   = enc_q;
        k_d     = k_q;

        busy    = 1'b0;
        done    = 1'b0;
        s_addr  = '0;
        s_wdata = '0;
        s_wren  = 1'b0;
        k_addr  = '0;
        d_addr  = '0;
        d_wdata = '0;
        d_wren  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    state_d = ST_RD_I;
                end
            end
            ST_RD_I: begin
                busy    = 1'b1;
                s_addr  = i_q + 8'd1;
                i_d     = i_q + 8'd1;
                state_d = ST_GET_I;
            end
            ST_GET_I: begin
                busy    = 1'b1;
                si_d    = s_rdata;
                j_d     = j_q + s_rdata;
                state_d = ST_RD_J;
            end
            ST_RD_J: begin
                busy    = 1'b1;
                s_addr  = j_q;
                state_d = ST_GET_J;
            end
            ST_GET_J: begin
                busy    = 1'b1;
                sj_d    = s_rdata;
                state_d = ST_WR_I;
            end
            ST_WR_I: begin
                busy    = 1'b1;
                s_addr  = i_q;
                s_wdata = sj_q;
                s_wren  = 1'b1;
                state_d = ST_WR_J;
            end
            ST_WR_J: begin
                // When i==j this rewrites the entry with its own value.
                busy    = 1'b1;
                s_addr  = j_q;
                s_wdata = si_q;
                s_wren  = 1'b1;
                state_d = ST_RD_F;
            end
            ST_RD_F: begin
                // The swap writes have landed by now, so this read sees them.
                busy    = 1'b1;
                s_addr  = si_q + sj_q;
                k_addr  = k_q[MSG_AW-1:0];
                state_d = ST_GET_F;
            end
            ST_GET_F: begin
                busy    = 1'b1;
                f_d     = s_rdata;
                enc_d   = k_rdata;
                state_d = ST_WR_D;
            end
            ST_WR_D: begin
                busy    = 1'b1;
                d_addr  = k_q[MSG_AW-1:0];
                d_wdata = f_q ^ enc_q;
                d_wren  = 1'b1;
                k_d     = k_q + K_W'(1);
                state_d = (k_q == K_LAST) ? ST_DONE : ST_RD_I;
            end
            ST_DONE: begin
                done = 1'b1;
                if (!start) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_prga_decrypt.sv
// -----------------------------------------------------------------------------
// tb_prga_decrypt
//
// Bench for prga_decrypt with MSG_LEN=4. Behavioural models of the S RAM and
// the encrypted ROM sit on the DUT ports. Stimulus pushes the hand-computed
// decrypted bytes into a queue. A monitor pops one entry on every d write
// and compares address and data. The stimulus also checks timing, the write
// counts and the final S contents.
// -----------------------------------------------------------------------------
module tb_prga_decrypt;

    localparam int LEN = 4;
    localparam int AW  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy, done;
    logic [7:0]    s_addr, s_wdata, s_rdata;
    logic          s_wren;
    logic [AW-1:0] k_addr, d_addr;
    logic [7:0]    k_rdata, d_wdata;
    logic          d_wren;

    prga_decrypt #(.MSG_LEN(LEN), .MSG_AW(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_wren  (s_wren),
        .s_rdata (s_rdata),
        .k_addr  (k_addr),
        .k_rdata (k_rdata),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_wren  (d_wren)
    );

    always #5 clk = ~clk;

    // Memory models: registered address, q valid in the following cycle.
    logic [7:0] s_mem [256];
    logic [7:0] k_mem [1 << AW];
    int         s_wcnt = 0;
    int         d_wcnt = 0;

    always @(posedge clk) begin
        s_rdata <= s_mem[s_addr];
        k_rdata <= k_mem[k_addr];
        if (s_wren) begin
            s_mem[s_addr] = s_wdata;
            s_wcnt++;
        end
        if (d_wren) d_wcnt++;
    end

    int        n_cmp = 0;
    int        n_bad = 0;
    bit [15:0] exp_q [$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every d write must match the oldest expected entry.
    always @(negedge clk) begin
        if (d_wren) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL d_write_unexpected: got addr %0d data 0x%02h, expected no write",
                         d_addr, d_wdata);
            end else begin
                bit [15:0] e;
                e = exp_q.pop_front();
                if ({8'(d_addr), d_wdata} !== e) begin
                    n_bad++;
                    $display("FAIL d_write: got addr %0d data 0x%02h, expected addr %0d data 0x%02h",
                             d_addr, d_wdata, e[15:8], e[7:0]);
                end else begin
                    $display("d write addr %0d data 0x%02h ok", d_addr, d_wdata);
                end
            end
        end
    end

    task automatic load_mem(input logic [7:0] s_fill, input bit identity,
                            input logic [7:0] enc);
        for (int a = 0; a < 256; a++) s_mem[a] = identity ? 8'(a) : s_fill;
        for (int a = 0; a < (1 << AW); a++) k_mem[a] = enc;
    endtask

    task automatic push_exp(input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3);
        exp_q.push_back({8'd0, d0});
        exp_q.push_back({8'd1, d1});
        exp_q.push_back({8'd2, d2});
        exp_q.push_back({8'd3, d3});
    endtask

    // Called just after a negedge. Start is sampled at the next edge (E0);
    // the loop index is the cycle number relative to E0.
    task automatic do_run(input int pulse_at, input bit hold, output int done_cyc,
                          output int busy_in, output int busy_out);
        done_cyc = -1;
        busy_in  = 0;
        busy_out = 0;
        start    = 1'b1;
        for (int cyc = 1; cyc <= 400 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            if (busy) begin
                if (cyc <= 9 * LEN) busy_in++;
                else busy_out++;
            end
            if (done) done_cyc = cyc;
            if (!hold) start = (cyc == pulse_at);
        end
    endtask

    task automatic full_run(input string tag, input int pulse_at, input bit hold);
        int dc, bi, bo, s0, d0;
        s0 = s_wcnt;
        d0 = d_wcnt;
        do_run(pulse_at, hold, dc, bi, bo);
        check({tag, "_done_cycle"}, dc, 9 * LEN + 1);
        check({tag, "_busy_in"}, bi, 9 * LEN);
        check({tag, "_busy_out"}, bo, 0);
        check({tag, "_s_writes"}, s_wcnt - s0, 2 * LEN);
        check({tag, "_d_writes"}, d_wcnt - d0, LEN);
        check({tag, "_sb_drain"}, exp_q.size(), 0);
        $display("run %s: done at cycle %0d", tag, dc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int snap_s, snap_d, hi;
        rst   = 1'b1;
        start = 1'b0;
        load_mem(8'h00, 1'b1, 8'h00);
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wren", {s_wren, d_wren}, 0);
        check("rst_addr", {s_addr, 6'(k_addr), 6'(d_addr)}, 0);
        check("rst_data", {s_wdata, d_wdata}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Identity S, zero ciphertext
        push_exp(8'h02, 8'h05, 8'h07, 8'h0D);
        full_run("ident", 0, 1'b0);
        check("s2", s_mem[2], 3);
        check("s3", s_mem[3], 5);
        check("s4", s_mem[4], 9);
        check("s5", s_mem[5], 2);
        check("s9", s_mem[9], 4);
        repeat (2) @(negedge clk);

        // All-0xFF S, 0xAA ciphertext: mod-256 wrap of j and si+sj
        load_mem(8'hFF, 1'b0, 8'hAA);
        push_exp(8'h55, 8'h55, 8'h55, 8'h55);
        full_run("wrap", 0, 1'b0);
        repeat (2) @(negedge clk);

        // Reset during GET_J of byte 2 (cycle 22)
        load_mem(8'h00, 1'b1, 8'h00);
        exp_q.push_back({8'd0, 8'h02});
        exp_q.push_back({8'd1, 8'h05});
        snap_s = s_wcnt;
        snap_d = d_wcnt;
        start  = 1'b1;
        for (int cyc = 1; cyc <= 22; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_wren", {s_wren, d_wren}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("mid_rst_s_writes", s_wcnt - snap_s, 4);
        check("mid_rst_d_writes", d_wcnt - snap_d, 2);
        check("mid_rst_sb_drain", exp_q.size(), 0);
        load_mem(8'h00, 1'b1, 8'h00);
        push_exp(8'h02, 8'h05, 8'h07, 8'h0D);
        full_run("restart", 0, 1'b0);
        repeat (2) @(negedge clk);

        // start held through completion
        load_mem(8'h00, 1'b1, 8'h00);
        push_exp(8'h02, 8'h05, 8'h07, 8'h0D);
        full_run("hold", 0, 1'b1);
        snap_s = s_wcnt;
        hi     = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) hi++;
        end
        check("hold_done_held", hi, 20);
        check("hold_no_rerun", s_wcnt - snap_s, 0);
        load_mem(8'h00, 1'b1, 8'h00);
        start = 1'b0;
        @(negedge clk);
        check("hold_done_fall", done, 0);
        push_exp(8'h02, 8'h05, 8'h07, 8'h0D);
        full_run("rearm", 0, 1'b0);
        repeat (2) @(negedge clk);

        // start re-pulsed mid-run is ignored
        load_mem(8'h00, 1'b1, 8'h00);
        push_exp(8'h02, 8'h05, 8'h07, 8'h0D);
        full_run("pulse", 10, 1'b0);
        check("pulse_s9", s_mem[9], 4);
        repeat (5) @(negedge clk);
        check("idle_after_pulse", {busy, done}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
